// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcodes, error codes and FSM states shared by the RPN core
package calc_pkg;

  localparam logic [4:0] OP_D0      = 5'd0;
  localparam logic [4:0] OP_D9      = 5'd9;
  localparam logic [4:0] OP_CLR_DIG = 5'd10;
  localparam logic [4:0] OP_CLR_NUM = 5'd11;
  localparam logic [4:0] OP_PUSH    = 5'd12;
  localparam logic [4:0] OP_POP     = 5'd13;
  localparam logic [4:0] OP_SWAP    = 5'd14;
  localparam logic [4:0] OP_NEG     = 5'd15;
  localparam logic [4:0] OP_ADD     = 5'd16;
  localparam logic [4:0] OP_SUB     = 5'd17;
  localparam logic [4:0] OP_MUL     = 5'd18;
  localparam logic [4:0] OP_DIV     = 5'd19;
  localparam logic [4:0] OP_SQR     = 5'd20;
  localparam logic [4:0] OP_CUBE    = 5'd21;
  localparam logic [4:0] OP_INC     = 5'd22;
  localparam logic [4:0] OP_DEC     = 5'd23;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_DIV0 = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_WB} state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int NW = $clog2(WIDTH + 1);

  logic [NW-1:0]  cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Partial remainder shifted left with the next dividend bit, and its trial subtraction
  always_comb begin
    trial = {rem, quotient[WIDTH-1]};
    diff  = trial - {1'b0, dsr};
  end

  // Quotient register doubles as the dividend shift register; one bit retires per cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
    end else if (start) begin
      cnt      <= NW'(WIDTH);
      rem      <= '0;
      dsr      <= divisor;
      quotient <= dividend;
    end else if (cnt != '0) begin
      cnt <= cnt - NW'(1);
      if (!diff[WIDTH]) begin
        rem      <= diff[WIDTH-1:0];
        quotient <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        rem      <= trial[WIDTH-1:0];
        quotient <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Flags the cycle of the final step, so quotient is complete on the following cycle
  assign done = (cnt == NW'(1));

endmodule

// File: rtl/rpn_core.sv
// rtl/rpn_core.sv - RPN calculator engine with operand stack and sequential divider
module rpn_core
  import calc_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             error,
  output logic [1:0]       error_code,
  output logic             busy
);

  localparam logic signed [WIDTH-1:0] TEN = WIDTH'(10);

  state_t           state, next_state;
  logic [4:0]       op;
  logic [WIDTH-1:0] stk [DEPTH];
  logic             div_neg;
  logic             div_start, div_done;
  logic [WIDTH-1:0] quot, div_res, mag_a, mag_b;
  logic [WIDTH-1:0] dig_res, bin_res, sq, cube;
  logic             has2, div_ok;

  assign has2       = (count >= CW'(2));
  assign key_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign top        = stk[0];
  assign next       = has2 ? stk[1] : '0;
  assign div_ok     = (op == OP_DIV) && !error && has2 && (stk[0] != '0);

  // Arithmetic results for the latched opcode, evaluated from the current stack
  always_comb begin
    dig_res = stk[0][WIDTH-1] ? (stk[0] * WIDTH'(10)) - WIDTH'(op)
                              : (stk[0] * WIDTH'(10)) + WIDTH'(op);
    sq      = stk[0] * stk[0];
    cube    = sq * stk[0];
    mag_a   = stk[1][WIDTH-1] ? -stk[1] : stk[1];
    mag_b   = stk[0][WIDTH-1] ? -stk[0] : stk[0];
    div_res = div_neg ? -quot : quot;
    case (op)
      OP_ADD:  bin_res = stk[1] + stk[0];
      OP_SUB:  bin_res = stk[1] - stk[0];
      default: bin_res = stk[1] * stk[0];
    endcase
  end

  // Control state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; the divider is launched from EXEC only for a legal DIV
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    case (state)
      S_IDLE: if (key_valid) next_state = S_EXEC;
      S_EXEC: begin
        if (div_ok) begin
          next_state = S_DIV;
          div_start  = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_DIV:   if (div_done) next_state = S_WB;
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Stack, count and error updates; keys are executed on the edge leaving EXEC
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      count      <= CW'(1);
      error      <= 1'b0;
      error_code <= ERR_NONE;
      op         <= '0;
      div_neg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (key_valid) op <= key_code;
        S_EXEC: begin
          if (op == OP_CLR_NUM) begin
            error      <= 1'b0;
            error_code <= ERR_NONE;
            stk[0]     <= '0;
          end else if (!error) begin
            case (op)
              OP_CLR_DIG: stk[0] <= WIDTH'($signed(stk[0]) / TEN);
              OP_NEG:     stk[0] <= -stk[0];
              OP_SQR:     stk[0] <= sq;
              OP_CUBE:    stk[0] <= cube;
              OP_INC:     stk[0] <= stk[0] + WIDTH'(1);
              OP_DEC:     stk[0] <= stk[0] - WIDTH'(1);
              OP_PUSH: begin
                if (count == CW'(DEPTH)) begin
                  error      <= 1'b1;
                  error_code <= ERR_OVF;
                end else begin
                  for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                  stk[0] <= '0;
                  count  <= count + CW'(1);
                end
              end
              OP_POP: begin
                if (count == CW'(1)) begin
                  error      <= 1'b1;
                  error_code <= ERR_UNF;
                end else begin
                  for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                  stk[DEPTH-1] <= '0;
                  count        <= count - CW'(1);
                end
              end
              OP_SWAP: begin
                if (!has2) begin
                  error      <= 1'b1;
                  error_code <= ERR_UNF;
                end else begin
                  stk[0] <= stk[1];
                  stk[1] <= stk[0];
                end
              end
              OP_ADD, OP_SUB, OP_MUL: begin
                if (!has2) begin
                  error      <= 1'b1;
                  error_code <= ERR_UNF;
                end else begin
                  stk[0] <= bin_res;
                  for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                  stk[DEPTH-1] <= '0;
                  count        <= count - CW'(1);
                end
              end
              OP_DIV: begin
                if (!has2) begin
                  error      <= 1'b1;
                  error_code <= ERR_UNF;
                end else if (stk[0] == '0) begin
                  error      <= 1'b1;
                  error_code <= ERR_DIV0;
                end else begin
                  div_neg <= stk[0][WIDTH-1] ^ stk[1][WIDTH-1];
                end
              end
              default: if (op <= OP_D9) stk[0] <= dig_res;
            endcase
          end
        end
        S_WB: begin
          stk[0] <= div_res;
          for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
          stk[DEPTH-1] <= '0;
          count        <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (quot)
  );

endmodule

// File: doc/rpn_core.md
Name: rpn_core

Overview:
- Parametrised RPN calculator engine: accepts decoded key events over a valid/ready handshake and executes them against an internal operand stack of DEPTH entries of WIDTH-bit two's-complement values.
- Sits between the numpad decoder and the BCD display.
- Generalises the fixed 32-bit controller: width/depth parameters, one-shot key handshake, sequential signed divider, stack overflow/underflow and divide-by-zero detection, signed digit entry.

Parameters:
- WIDTH, 32: operand width in bits (≥ 8).
- DEPTH, 16: stack entries (≥ 2).
- CW, $clog2(DEPTH+1): count width (derived, localparam).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  key event present.
- key_code  in  5  opcode from calc_pkg.
- key_ready  out  1  core can accept a key.
- top  out  WIDTH  stack entry 0.
- next  out  WIDTH  stack entry 1 (0 when count < 2).
- count  out  CW  number of live entries, 1..DEPTH.
- error  out  1  sticky error flag.
- error_code  out  2  0 none, 1 overflow, 2 underflow, 3 div-by-zero.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset, asynchronous: all entries 0; count=1; error=0; error_code=0; state IDLE; key_ready=1; busy=0.
- Handshake: a key is accepted on an edge where key_valid & key_ready. key_code is latched at acceptance. key_ready = (state==IDLE). A held key_valid is not re-accepted until ready returns.
- FSM states: IDLE, EXEC, DIV, WB.
  - IDLE→EXEC on accept.
  - EXEC→IDLE for every opcode except DIV.
  - EXEC→DIV for DIV with valid operands.
  - DIV→WB on divider done.
  - WB→IDLE.
- Latency:
  - Non-DIV ops: key accepted at edge k; stack updated at edge k+1; key_ready low for exactly 1 cycle.
  - DIV: stack updated and key_ready reasserted WIDTH+2 cycles after acceptance.
- Error gating: while error=1, every opcode except CLR_NUM is accepted and discarded. CLR_NUM clears error and error_code and sets top=0; count is unchanged.
- Digit d (0..9): top ← top*10+d if top ≥ 0, else top*10−d. Result wraps mod 2^WIDTH.
- CLR_DIG: top ← top/10, signed, truncated toward zero.
- NEG: top ← −top, wraps.
- PUSH:
  - count==DEPTH → error, code 1, no stack change.
  - Otherwise shift entries down, new top=0, count+1.
- POP:
  - count==1 → error, code 2.
  - Otherwise shift entries up, count−1; the vacated bottom entry becomes 0.
- SWAP: count<2 → error, code 2. Otherwise exchange top and next.
- Binary ops ADD/SUB/MUL/DIV (result = next op top):
  - count<2 → error, code 2, no change.
  - Otherwise the result replaces next, the stack pops, count−1.
  - ADD/SUB/MUL keep the low WIDTH bits.
- DIV:
  - top==0 → error, code 3, stack unchanged, no DIV state.
  - Operands are converted to magnitudes, an unsigned quotient is computed, then negated if the signs differ.
  - Truncates toward zero; remainder discarded. MIN/−1 yields MIN (wrap).
- Unary ops, low WIDTH bits kept: SQR top←top*top; CUBE top←top*top*top; INC top←top+1; DEC top←top−1.
- Undefined opcodes are accepted and ignored (1-cycle EXEC, no change).
- Reset during DIV/WB aborts the operation; state returns to the reset values above.
- next output: entry 1 when count≥2, else 0.

Decomposition:
- calc_pkg:
  - 5-bit opcode constants, all distinct: D0..D9=0..9, CLR_DIG=10, CLR_NUM=11, PUSH=12, POP=13, SWAP=14, NEG=15, ADD=16, SUB=17, MUL=18, DIV=19, SQR=20, CUBE=21, INC=22, DEC=23.
  - Error code constants.
  - FSM state encoding.
- Sub-module seq_divider (WIDTH param):
  - Unsigned restoring divider, one quotient bit per cycle.
  - Interface: start pulse, dividend, divisor, done pulse exactly WIDTH cycles after start, quotient.
  - Shares the rpn_core clock and asynchronous reset.

Test Plan:
- Keys 1,2,PUSH,3,ADD at WIDTH=32 → top=15, count=1, error=0. Each acceptance drops key_ready for exactly 1 cycle.
- Keys 7,NEG,PUSH,2,DIV → top=−3, count=1. key_ready reasserts 34 cycles after the DIV acceptance. A key_valid pulse during busy is not accepted.
- Keys 5,PUSH,DIV (top=0) → error=1, code 3, top=0, next=5, count=2. A subsequent ADD is ignored. CLR_NUM clears the error.
- DEPTH=4: PUSH ×3 → count=4. A 4th PUSH → error code 1, count=4. After reset, POP → error code 2.
- Keys 5,NEG,3 → top=−53; CLR_DIG → −5. At WIDTH=8: keys 9,9 → 99; SQR → 99*99 mod 256 = 73 (0x49).
- Assert reset 10 cycles into a DIV → top=0, count=1, key_ready=1, busy=0 immediately. A new ADD after release gives error code 2.
